// File: rtl/ff_net_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ff_net_seq_pkg
// Purpose  : Shared types and address-map helpers for the ff_network
//            bus-master sequencer.
// Contents : state_t    - sequencer states
//            f_n_w      - number of weight words
//            f_*_addr   - commit / input / output base addresses
//            C_COMMIT_ONES - all-ones commit data (slice to data width)
// Revision : 1.0 - initial release
// ============================================================================
package ff_net_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_W   = 3'd1,
    ST_COMMIT_W = 3'd2,
    ST_LOAD_I   = 3'd3,
    ST_COMMIT_I = 3'd4,
    ST_WAIT     = 3'd5,
    ST_READ     = 3'd6,
    ST_OUT      = 3'd7
  } state_t;

  // Wide enough for any practical data word; users slice [WIDTH-1:0].
  localparam int C_MAX_WIDTH = 256;
  localparam logic [C_MAX_WIDTH-1:0] C_COMMIT_ONES = '1;

  function automatic int f_n_w(input int li, input int lm, input int lo);
    return li * lm + lm * lo;
  endfunction

  function automatic int f_wcommit_addr(input int li, input int lm, input int lo);
    return f_n_w(li, lm, lo);
  endfunction

  function automatic int f_in_base_addr(input int li, input int lm, input int lo);
    return f_n_w(li, lm, lo) + 1;
  endfunction

  function automatic int f_icommit_addr(input int li, input int lm, input int lo);
    return f_n_w(li, lm, lo) + li + 1;
  endfunction

  function automatic int f_out_base_addr(input int li, input int lm, input int lo);
    return f_n_w(li, lm, lo) + li + 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ff_net_seq_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : ff_net_seq_watchdog
// Purpose  : Load/enable/expire cycle counter bounding the WAIT phase.
// Ports    : clk, reset (async active-low)
//            i_load   - clear the count (asserted outside WAIT)
//            i_en     - count one cycle
//            o_expire - high on the TIMEOUT-th enabled cycle
// Revision : 1.0 - initial release
// ============================================================================
module ff_net_seq_watchdog
  import ff_net_seq_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);

  localparam int             c_CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(TIMEOUT - 1);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

  logic [c_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != c_LAST)) begin
      r_cnt <= r_cnt + c_ONE;
    end
  end

  assign o_expire = i_en && !i_load && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/ff_net_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ff_net_sequencer
// Purpose  : Sole register-bus master of one ff_network. Streams weights and
//            inputs from the host into the network, issues the commit
//            strobes, waits for net_ready and streams the outputs back.
// Ports    : clk, reset (async active-low)
//            cmd_start/cmd_wload      - pass request (wload: weights first)
//            s_valid/s_ready/s_data   - host word stream
//            m_valid/m_ready/m_data/m_last - result stream
//            busy, err                - status (err = sticky WAIT timeout)
//            net_address/net_in_d/net_write/net_read - network bus (registered)
//            net_out_d, net_ready     - network read data / outputs valid
// Config   : FF_NET_SEQ_WATCHDOG_EN enables the WAIT timeout watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module ff_net_sequencer
  import ff_net_seq_pkg::*;
#(
  parameter int LENGHT_I   = 2,
  parameter int LENGHT_MID = 2,
  parameter int LENGHT_O   = 2,
  parameter int WIDTH      = 32,
  parameter int WIDTH_ADDR = $clog2(LENGHT_I*LENGHT_MID + LENGHT_MID*LENGHT_O
                                    + LENGHT_I + LENGHT_O + 3),
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_start,
  input  logic                  cmd_wload,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [WIDTH-1:0]      s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WIDTH-1:0]      m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  err,
  output logic [WIDTH_ADDR-1:0] net_address,
  output logic [WIDTH-1:0]      net_in_d,
  output logic                  net_write,
  output logic                  net_read,
  input  logic [WIDTH-1:0]      net_out_d,
  input  logic                  net_ready
);

  localparam int c_N_W = f_n_w(LENGHT_I, LENGHT_MID, LENGHT_O);
  localparam logic [WIDTH_ADDR-1:0] c_ADDR_WCOMMIT =
    WIDTH_ADDR'(f_wcommit_addr(LENGHT_I, LENGHT_MID, LENGHT_O));
  localparam logic [WIDTH_ADDR-1:0] c_ADDR_IN_BASE =
    WIDTH_ADDR'(f_in_base_addr(LENGHT_I, LENGHT_MID, LENGHT_O));
  localparam logic [WIDTH_ADDR-1:0] c_ADDR_ICOMMIT =
    WIDTH_ADDR'(f_icommit_addr(LENGHT_I, LENGHT_MID, LENGHT_O));
  localparam logic [WIDTH_ADDR-1:0] c_ADDR_OUT_BASE =
    WIDTH_ADDR'(f_out_base_addr(LENGHT_I, LENGHT_MID, LENGHT_O));
  localparam logic [WIDTH_ADDR-1:0] c_LAST_W = WIDTH_ADDR'(c_N_W - 1);
  localparam logic [WIDTH_ADDR-1:0] c_LAST_I = WIDTH_ADDR'(LENGHT_I - 1);
  localparam logic [WIDTH_ADDR-1:0] c_LAST_O = WIDTH_ADDR'(LENGHT_O - 1);
  localparam logic [WIDTH_ADDR-1:0] c_ONE    = WIDTH_ADDR'(1);
  localparam logic [WIDTH-1:0]      c_COMMIT = C_COMMIT_ONES[WIDTH-1:0];

  state_t                r_state;
  state_t                w_next_state;
  logic [WIDTH_ADDR-1:0] r_word_cnt;
  logic [WIDTH_ADDR-1:0] r_out_cnt;
  logic [WIDTH_ADDR-1:0] w_out_idx;
  logic [WIDTH_ADDR-1:0] r_net_address;
  logic [WIDTH-1:0]      r_net_in_d;
  logic                  r_net_write;
  logic                  r_net_read;
  logic                  r_cap;
  logic                  r_m_valid;
  logic                  r_m_last;
  logic [WIDTH-1:0]      r_m_data;
  logic                  r_err;
  logic                  w_s_ready;
  logic                  w_busy;
  logic                  w_s_hs;
  logic                  w_m_hs;
  logic                  w_start;
  logic                  w_wd_expire;

  assign w_s_hs  = s_valid && w_s_ready;
  assign w_m_hs  = r_m_valid && m_ready;
  assign w_start = cmd_start && (r_state == ST_IDLE);
  // Leaving OUT towards READ, the counter advances on the same edge that
  // registers the next read address, so look one index ahead.
  assign w_out_idx = (r_state == ST_OUT) ? (r_out_cnt + c_ONE) : r_out_cnt;

`ifdef FF_NET_SEQ_WATCHDOG_EN
  ff_net_seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .i_load   (r_state != ST_WAIT),
    .i_en     (r_state == ST_WAIT),
    .o_expire (w_wd_expire)
  );
`else
  assign w_wd_expire = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:     if (cmd_start) w_next_state = cmd_wload ? ST_LOAD_W : ST_LOAD_I;
      ST_LOAD_W:   if (w_s_hs && (r_word_cnt == c_LAST_W)) w_next_state = ST_COMMIT_W;
      ST_COMMIT_W: w_next_state = ST_LOAD_I;
      ST_LOAD_I:   if (w_s_hs && (r_word_cnt == c_LAST_I)) w_next_state = ST_COMMIT_I;
      ST_COMMIT_I: w_next_state = ST_WAIT;
      ST_WAIT: begin
        if (net_ready)        w_next_state = ST_READ;
        else if (w_wd_expire) w_next_state = ST_IDLE;
      end
      ST_READ:     w_next_state = ST_OUT;
      ST_OUT:      if (w_m_hs) w_next_state = (r_out_cnt == c_LAST_O) ? ST_IDLE : ST_READ;
      default:     w_next_state = ST_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    w_s_ready = 1'b0;
    w_busy    = 1'b1;
    case (r_state)
      ST_IDLE:              w_busy    = 1'b0;
      ST_LOAD_W, ST_LOAD_I: w_s_ready = 1'b1;
      default:              ;
    endcase
  end

  // Counters, registered bus and result capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_word_cnt    <= '0;
      r_out_cnt     <= '0;
      r_net_address <= '0;
      r_net_in_d    <= '0;
      r_net_write   <= 1'b0;
      r_net_read    <= 1'b0;
      r_cap         <= 1'b0;
      r_m_valid     <= 1'b0;
      r_m_last      <= 1'b0;
      r_m_data      <= '0;
      r_err         <= 1'b0;
    end else begin
      r_net_write <= 1'b0;
      r_net_read  <= 1'b0;
      if (w_start) begin
        r_word_cnt <= '0;
        r_out_cnt  <= '0;
        r_err      <= 1'b0;
      end
      case (r_state)
        ST_LOAD_W, ST_LOAD_I: begin
          if (w_s_hs) begin
            r_net_write   <= 1'b1;
            r_net_address <= (r_state == ST_LOAD_W) ? r_word_cnt
                                                    : (c_ADDR_IN_BASE + r_word_cnt);
            r_net_in_d    <= s_data;
            // Last word of a phase rewinds the counter for the next phase.
            if (((r_state == ST_LOAD_W) && (r_word_cnt == c_LAST_W)) ||
                ((r_state == ST_LOAD_I) && (r_word_cnt == c_LAST_I)))
              r_word_cnt <= '0;
            else
              r_word_cnt <= r_word_cnt + c_ONE;
          end
        end
        ST_COMMIT_W: begin
          r_net_write   <= 1'b1;
          r_net_address <= c_ADDR_WCOMMIT;
          r_net_in_d    <= c_COMMIT;
        end
        ST_COMMIT_I: begin
          r_net_write   <= 1'b1;
          r_net_address <= c_ADDR_ICOMMIT;
          r_net_in_d    <= c_COMMIT;
        end
        ST_WAIT: if (!net_ready && w_wd_expire) r_err <= 1'b1;
        default: ;
      endcase
      if (w_next_state == ST_READ) begin
        r_net_read    <= 1'b1;
        r_net_address <= c_ADDR_OUT_BASE + w_out_idx;
      end
      // Network read data arrives the cycle after net_read.
      r_cap <= (r_state == ST_READ);
      if (r_cap) begin
        r_m_data  <= net_out_d;
        r_m_valid <= 1'b1;
        r_m_last  <= (r_out_cnt == c_LAST_O);
      end else if (w_m_hs) begin
        r_m_valid <= 1'b0;
        r_m_last  <= 1'b0;
        r_out_cnt <= r_out_cnt + c_ONE;
      end
    end
  end

  assign s_ready     = w_s_ready;
  assign busy        = w_busy;
  assign err         = r_err;
  assign m_valid     = r_m_valid;
  assign m_data      = r_m_data;
  assign m_last      = r_m_last;
  assign net_address = r_net_address;
  assign net_in_d    = r_net_in_d;
  assign net_write   = r_net_write;
  assign net_read    = r_net_read;

endmodule
`default_nettype wire

// File: tb/tb_ff_net_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ff_net_sequencer
// Purpose  : Directed self-checking bench for ff_net_sequencer with a small
//            behavioural ff_network model (write log, output memory,
//            delayed net_ready).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ff_net_sequencer;

  localparam int W  = 32;
  localparam int WA = $clog2(2*2 + 2*2 + 2 + 2 + 3);
`ifdef FF_NET_SEQ_WATCHDOG_EN
  localparam int TB_TIMEOUT = 16;
`else
  localparam int TB_TIMEOUT = 1024;
`endif
  localparam logic [W-1:0] ONES = 32'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_start = 1'b0, cmd_wload = 1'b0;
  logic          s_valid = 1'b0, s_ready;
  logic [W-1:0]  s_data = '0;
  logic          m_valid, m_ready = 1'b1, m_last;
  logic [W-1:0]  m_data;
  logic          busy, err;
  logic [WA-1:0] net_address;
  logic [W-1:0]  net_in_d, net_out_d = '0;
  logic          net_write, net_read, net_ready = 1'b0;

  int checks = 0, failures = 0;
  int cyc = 0, rd_cyc = 0, rdy_dly = 0;
  bit both_seen = 0, mv_seen = 0, model_en = 1;
  logic [WA-1:0] wr_addr[$];
  logic [W-1:0]  wr_data[$];
  int            wr_cyc[$];

  ff_net_sequencer #(
    .LENGHT_I(2), .LENGHT_MID(2), .LENGHT_O(2), .WIDTH(W), .WIDTH_ADDR(WA),
    .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_wload(cmd_wload),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .err(err), .net_address(net_address), .net_in_d(net_in_d),
    .net_write(net_write), .net_read(net_read), .net_out_d(net_out_d),
    .net_ready(net_ready)
  );

  always #5 clk = ~clk;

  // Network model: logs writes, answers reads one cycle later, raises
  // net_ready a few cycles after the input commit.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_valid) mv_seen = 1;
    if (net_write && net_read) both_seen = 1;
    if (net_write) begin
      wr_addr.push_back(net_address);
      wr_data.push_back(net_in_d);
      wr_cyc.push_back(cyc);
    end
    if (net_read) begin
      rd_cyc = cyc;
      net_out_d <= (net_address == WA'(12)) ? 32'h1A0 :
                   (net_address == WA'(13)) ? 32'h0FF : 32'hDEAD_BEEF;
    end
    if (!reset || (cmd_start && !busy)) begin
      net_ready <= 1'b0;
      rdy_dly   <= 0;
    end else if (model_en && net_write && net_address == WA'(11) && net_in_d == ONES) begin
      rdy_dly <= 5;
    end else if (rdy_dly != 0) begin
      rdy_dly <= rdy_dly - 1;
      if (rdy_dly == 1) net_ready <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
  endtask

  task automatic start_pass(input bit wload);
    cmd_start = 1'b1; cmd_wload = wload;
    @(negedge clk);
    cmd_start = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] d, input bit gap);
    int n;
    n = 0;
    s_valid = 1'b1; s_data = d;
    while (!s_ready && n < 100) begin @(negedge clk); n++; end
    chk("s_ready_wait", {63'd0, s_ready}, 64'd1);
    @(negedge clk);
    s_valid = 1'b0;
    if (gap) @(negedge clk);
  endtask

  task automatic wait_writes(input int n);
    int k;
    k = 0;
    while (wr_addr.size() < n && k < 200) begin @(negedge clk); k++; end
    chk("write_count", 64'(wr_addr.size()), 64'(n));
  endtask

  task automatic chk_write(input int i, input logic [WA-1:0] a, input logic [W-1:0] d);
    chk($sformatf("write%0d", i), (64'(wr_addr[i]) << 32) | 64'(wr_data[i]),
        (64'(a) << 32) | 64'(d));
  endtask

  task automatic get_result(input logic [W-1:0] exp_d, input bit exp_last, input bit stall);
    int n;
    n = 0;
    while (!m_valid && n < 200) begin @(negedge clk); n++; end
    chk("m_valid_wait", {63'd0, m_valid}, 64'd1);
    chk("m_valid_latency", 64'(cyc), 64'(rd_cyc + 2));
    chk("m_data", 64'(m_data), 64'(exp_d));
    chk("m_last", {63'd0, m_last}, {63'd0, exp_last});
    if (stall) begin
      m_ready = 1'b0;
      repeat (4) @(negedge clk);
      chk("stall_valid", {63'd0, m_valid}, 64'd1);
      chk("stall_data", 64'(m_data), 64'(exp_d));
      m_ready = 1'b1;
    end
    chk("busy_before_hs", {63'd0, busy}, 64'd1);
    @(negedge clk);
    chk("m_valid_drop", {63'd0, m_valid}, 64'd0);
    if (exp_last) chk("busy_fall", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    // ---- reset values ----
    repeat (2) @(negedge clk);
    chk("rst_net_address", 64'(net_address), 64'd0);
    chk("rst_net_in_d", 64'(net_in_d), 64'd0);
    chk("rst_strobes", {60'd0, net_write, net_read, m_valid, m_last}, 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_status", {61'd0, busy, err, s_ready}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // ---- reset mid-LOAD_W after three words ----
    start_pass(1'b1);
    chk("start_busy", {62'd0, busy, s_ready}, 64'd3);
    send_word(32'd11, 1'b0);
    send_word(32'd12, 1'b0);
    send_word(32'd13, 1'b0);
    reset = 1'b0;
    #1;
    chk("midrst_bus", {63'd0, net_write} | 64'(net_address) | 64'(net_in_d), 64'd0);
    chk("midrst_status", {62'd0, busy, s_ready}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    s_valid = 1'b1; s_data = 32'd99;
    repeat (5) @(negedge clk);
    s_valid = 1'b0;
    chk("midrst_no_more_writes", 64'(wr_addr.size()), 64'd2);
    chk("midrst_idle", {63'd0, busy}, 64'd0);
    clear_log();

    // ---- pass 1: weights 1..8 then inputs 500,1000 ----
    start_pass(1'b1);
    for (int i = 1; i <= 8; i++) send_word(W'(i), 1'b0);
    send_word(32'd500, 1'b0);
    send_word(32'd1000, 1'b0);
    wait_writes(12);
    for (int i = 0; i < 8; i++) chk_write(i, WA'(i), W'(i + 1));
    chk_write(8, WA'(8), ONES);
    chk_write(9, WA'(9), 32'd500);
    chk_write(10, WA'(10), 32'd1000);
    chk_write(11, WA'(11), ONES);
    chk("weights_back_to_back", 64'(wr_cyc[7] - wr_cyc[0]), 64'd7);
    chk("wcommit_follows", 64'(wr_cyc[8] - wr_cyc[7]), 64'd1);
    chk("icommit_follows", 64'(wr_cyc[11] - wr_cyc[10]), 64'd1);
    get_result(32'h1A0, 1'b0, 1'b0);
    get_result(32'h0FF, 1'b1, 1'b0);
    clear_log();

    // ---- pass 2: inputs only, gapped stream, stalled result, stray start ----
    start_pass(1'b0);
    send_word(32'd300, 1'b1);
    send_word(32'd800, 1'b1);
    cmd_start = 1'b1; cmd_wload = 1'b1;
    chk("wait_s_ready_low", {62'd0, busy, s_ready}, 64'd2);
    @(negedge clk);
    cmd_start = 1'b0;
    get_result(32'h1A0, 1'b0, 1'b1);
    get_result(32'h0FF, 1'b1, 1'b0);
    chk("pass2_write_count", 64'(wr_addr.size()), 64'd3);
    chk_write(0, WA'(9), 32'd300);
    chk_write(1, WA'(10), 32'd800);
    chk_write(2, WA'(11), ONES);
    chk("gapped_spacing", 64'(wr_cyc[1] - wr_cyc[0]), 64'd2);
    repeat (5) @(negedge clk);
    chk("stray_start_ignored", 64'(wr_addr.size()), 64'd3);
    chk("stays_idle", {63'd0, busy}, 64'd0);
    chk("never_rd_and_wr", {63'd0, both_seen}, 64'd0);
    chk("err_clear", {63'd0, err}, 64'd0);

`ifdef FF_NET_SEQ_WATCHDOG_EN
    // ---- watchdog: net_ready never rises ----
    begin
      int n;
      clear_log();
      model_en = 0;
      mv_seen = 0;
      start_pass(1'b0);
      send_word(32'd7, 1'b0);
      send_word(32'd8, 1'b0);
      wait_writes(3);
      n = 0;
      while (busy && n < 100) begin @(negedge clk); n++; end
      chk("wd_busy_drop", {63'd0, busy}, 64'd0);
      chk("wd_timing", 64'(cyc - wr_cyc[2]), 64'd16);
      chk("wd_err_set", {63'd0, err}, 64'd1);
      chk("wd_no_result", {63'd0, mv_seen}, 64'd0);
      start_pass(1'b0);
      chk("wd_err_cleared", {62'd0, err, busy}, 64'd1);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
